// File: rtl/ksa_share_arbiter.sv
// Round-robin arbiter sharing one Kogge-Stone adder among NREQ requesters.
// Two-stage pipeline (operand reg, sum reg) with full backpressure.

`ifndef INPUTSIZE
`define INPUTSIZE 64
`endif

module variable_ksa #(
  parameter int W = `INPUTSIZE
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic [W:0]   sum
);

  localparam int L = $clog2(W);

  logic [W-1:0] g;
  logic [W-1:0] p;
  logic [W-1:0] p0;

  assign p0 = a ^ b;

  // Prefix tree: span doubles per level, g/p hold group generate/propagate
  always_comb begin
    g = a & b;
    p = p0;
    for (int k = 0; k < L; k++) begin
      g = g | (p & (g << (1 << k)));
      p = p & (p << (1 << k));
    end
  end

  assign sum = {g[W-1], p0 ^ {g[W-2:0], 1'b0}};

endmodule

module ksa_share_arbiter #(
  parameter int NREQ  = 4,
  parameter int WIDTH = 64,
  parameter int IDW   = $clog2(NREQ)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NREQ-1:0]       req_valid,
  output logic [NREQ-1:0]       req_ready,
  input  logic [NREQ*WIDTH-1:0] req_a,
  input  logic [NREQ*WIDTH-1:0] req_b,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [WIDTH:0]        rsp_sum,
  output logic [IDW-1:0]        rsp_id
);

  generate
    if (WIDTH != `INPUTSIZE) begin : g_bad_width
      $error("ksa_share_arbiter: WIDTH must equal INPUTSIZE");
    end
    if (NREQ < 2 || NREQ > 16) begin : g_bad_nreq
      $error("ksa_share_arbiter: NREQ must be in 2..16");
    end
  endgenerate

  logic             s1_valid;
  logic [WIDTH-1:0] s1_a;
  logic [WIDTH-1:0] s1_b;
  logic [IDW-1:0]   s1_id;
  logic [IDW-1:0]   ptr;

  logic             s1_en;
  logic             s2_en;
  logic             any;
  logic [IDW-1:0]   gnt;
  logic [IDW-1:0]   ptr_nxt;
  logic             xfer;
  logic [WIDTH:0]   sum;

  assign s2_en = !rsp_valid || rsp_ready;
  assign s1_en = !s1_valid || s2_en;

  // Descending scan so the lowest offset from ptr wins
  always_comb begin
    int idx;
    any = 1'b0;
    gnt = '0;
    idx = 0;
    for (int o = NREQ - 1; o >= 0; o--) begin
      idx = (int'(ptr) + o) % NREQ;
      if (req_valid[idx]) begin
        any = 1'b1;
        gnt = idx[IDW-1:0];
      end
    end
  end

  assign xfer = !rst && s1_en && any;

  always_comb begin
    req_ready = '0;
    if (xfer) begin
      req_ready[gnt] = 1'b1;
    end
  end

  assign ptr_nxt = (gnt == IDW'(NREQ - 1)) ? '0 : gnt + 1'b1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1_a     <= '0;
      s1_b     <= '0;
      s1_id    <= '0;
      ptr      <= '0;
    end else if (s1_en) begin
      s1_valid <= xfer;
      if (xfer) begin
        s1_a  <= req_a[int'(gnt)*WIDTH +: WIDTH];
        s1_b  <= req_b[int'(gnt)*WIDTH +: WIDTH];
        s1_id <= gnt;
        ptr   <= ptr_nxt;
      end
    end
  end

  variable_ksa #(
    .W(WIDTH)
  ) u_ksa (
    .a  (s1_a),
    .b  (s1_b),
    .sum(sum)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rsp_valid <= 1'b0;
      rsp_sum   <= '0;
      rsp_id    <= '0;
    end else if (s2_en) begin
      rsp_valid <= s1_valid;
      rsp_sum   <= sum;
      rsp_id    <= s1_id;
    end
  end

endmodule

// File: tb/tb_ksa_share_arbiter.sv
// Directed bench for ksa_share_arbiter (NREQ=4, WIDTH=64).
// Inputs change 1ns after the rising edge; outputs sampled 1ns later.

module tb_ksa_share_arbiter;

  localparam int N = 4;
  localparam int W = 64;

  logic           clk;
  logic           rst;
  logic [N-1:0]   req_valid;
  logic [N-1:0]   req_ready;
  logic [N*W-1:0] req_a;
  logic [N*W-1:0] req_b;
  logic           rsp_valid;
  logic           rsp_ready;
  logic [W:0]     rsp_sum;
  logic [1:0]     rsp_id;

  int nvec;
  int nerr;

  ksa_share_arbiter #(
    .NREQ (N),
    .WIDTH(W)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .req_valid(req_valid),
    .req_ready(req_ready),
    .req_a    (req_a),
    .req_b    (req_b),
    .rsp_valid(rsp_valid),
    .rsp_ready(rsp_ready),
    .rsp_sum  (rsp_sum),
    .rsp_id   (rsp_id)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [127:0] obs,
                     input logic [127:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic setop(input int i, input logic [W-1:0] a,
                       input logic [W-1:0] b);
    req_a[i*W +: W] = a;
    req_b[i*W +: W] = b;
  endtask

  task automatic chk_rsp(input string tag, input logic v,
                         input logic [W:0] s, input logic [1:0] id);
    chk({tag, ".v"}, rsp_valid, v);
    if (v) begin
      chk({tag, ".sum"}, rsp_sum, s);
      chk({tag, ".id"}, rsp_id, id);
    end
  endtask

  logic [W-1:0] ones;
  logic [W:0]   big;

  initial begin
    nvec = 0;
    nerr = 0;
    ones = '1;
    big  = {1'b1, ones[W-1:1], 1'b0};
    rst = 1'b1;
    req_valid = 4'b1111;
    req_a = '0;
    req_b = '0;
    rsp_ready = 1'b1;

    // reset state, ready gated while rst high
    #1;
    chk("rst.ready", req_ready, 4'b0000);
    chk("rst.v", rsp_valid, 1'b0);
    chk("rst.sum", rsp_sum, '0);
    chk("rst.id", rsp_id, 2'd0);
    #2;
    cyc();
    rst = 1'b0;

    // single request
    req_valid = 4'b0001;
    setop(0, 5, 7);
    #1 chk("single.ready", req_ready, 4'b0001);
    cyc();
    req_valid = 4'b0000;
    #1 chk_rsp("single.t1", 1'b0, '0, 2'd0);
    cyc();
    #1 chk_rsp("single.t2", 1'b1, 65'd12, 2'd0);

    // reset to bring pointer back to 0
    rst = 1'b1;
    #1 chk("rst2.v", rsp_valid, 1'b0);
    #2 rst = 1'b0;
    cyc();

    // contention 1111
    for (int i = 0; i < N; i++) setop(i, W'(i + 1), W'(10 * (i + 1)));
    req_valid = 4'b1111;
    for (int s = 0; s < 7; s++) begin
      if (s == 4) req_valid = 4'b0000;
      #1;
      chk($sformatf("cont%0d.ready", s), req_ready,
          (s < 4) ? (4'b0001 << s) : 4'b0000);
      if (s >= 2 && s < 6)
        chk_rsp($sformatf("cont%0d", s), 1'b1,
                65'(11 * (s - 1)), 2'(s - 2));
      else
        chk_rsp($sformatf("cont%0d", s), 1'b0, '0, 2'd0);
      cyc();
    end

    // backpressure: three ops from req 2, rsp_ready low 4 cycles
    rsp_ready = 1'b0;
    req_valid = 4'b0100;
    setop(2, 100, 1);
    #1 chk("bp0.ready", req_ready, 4'b0100);
    cyc();
    setop(2, 200, 2);
    #1 chk("bp1.ready", req_ready, 4'b0100);
    chk_rsp("bp1", 1'b0, '0, 2'd0);
    cyc();
    setop(2, 300, 3);
    #1 chk("bp2.ready", req_ready, 4'b0000);
    chk_rsp("bp2", 1'b1, 65'd101, 2'd2);
    cyc();
    #1 chk("bp3.ready", req_ready, 4'b0000);
    chk_rsp("bp3", 1'b1, 65'd101, 2'd2);
    cyc();
    rsp_ready = 1'b1;
    #1 chk("bp4.ready", req_ready, 4'b0100);
    chk_rsp("bp4", 1'b1, 65'd101, 2'd2);
    cyc();
    req_valid = 4'b0000;
    #1 chk_rsp("bp5", 1'b1, 65'd202, 2'd2);
    cyc();
    #1 chk_rsp("bp6", 1'b1, 65'd303, 2'd2);
    cyc();
    #1 chk_rsp("bp7", 1'b0, '0, 2'd0);

    // carry boundary: zeros via req 0, all-ones via req 3
    req_valid = 4'b0001;
    setop(0, 0, 0);
    #1 chk("cy0.ready", req_ready, 4'b0001);
    cyc();
    req_valid = 4'b1000;
    setop(3, ones, ones);
    #1 chk("cy1.ready", req_ready, 4'b1000);
    cyc();
    req_valid = 4'b0000;
    #1 chk_rsp("cy2", 1'b1, '0, 2'd0);
    cyc();
    #1 chk_rsp("cy3", 1'b1, big, 2'd3);
    cyc();

    // fairness from pointer 0 with 1001 held
    req_valid = 4'b1001;
    setop(0, 1, 0);
    setop(3, 3, 0);
    #1 chk("fr0.ready", req_ready, 4'b0001);
    chk_rsp("fr0", 1'b0, '0, 2'd0);
    cyc();
    #1 chk("fr1.ready", req_ready, 4'b1000);
    cyc();
    #1 chk("fr2.ready", req_ready, 4'b0001);
    chk_rsp("fr2", 1'b1, 65'd1, 2'd0);
    cyc();
    #1 chk("fr3.ready", req_ready, 4'b1000);
    chk_rsp("fr3", 1'b1, 65'd3, 2'd3);
    cyc();
    req_valid = 4'b0000;
    #1 chk_rsp("fr4", 1'b1, 65'd1, 2'd0);
    cyc();
    #1 chk_rsp("fr5", 1'b1, 65'd3, 2'd3);
    cyc();

    // reset mid-flight with both stages full
    req_valid = 4'b0001;
    setop(0, 9, 1);
    #1 chk("rm0.ready", req_ready, 4'b0001);
    cyc();
    rsp_ready = 1'b0;
    #1 chk("rm1.ready", req_ready, 4'b0001);
    cyc();
    #1 chk("rm2.ready", req_ready, 4'b0000);
    chk_rsp("rm2", 1'b1, 65'd10, 2'd0);
    rst = 1'b1;
    #1;
    chk("rm.rst.v", rsp_valid, 1'b0);
    chk("rm.rst.sum", rsp_sum, '0);
    chk("rm.rst.ready", req_ready, 4'b0000);
    req_valid = 4'b0000;
    rsp_ready = 1'b1;
    #1 rst = 1'b0;
    cyc();
    #1 chk_rsp("rm3", 1'b0, '0, 2'd0);
    cyc();
    #1 chk_rsp("rm4", 1'b0, '0, 2'd0);
    req_valid = 4'b1001;
    #1 chk("rm.ptr0", req_ready, 4'b0001);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

  initial begin
    #20000;
    nerr++;
    $display("FAIL timeout observed=running expected=finished");
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $fatal(1, "timeout");
  end

endmodule
